// File: rtl/inc16.sv
// Registered WIDTH-bit incrementer (A + 1 with carry-out) with a valid qualifier.
// Optional sticky overflow flag enabled by defining INC16_OVF_STICKY_EN.
module inc16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
`ifdef INC16_OVF_STICKY_EN
  ,
  output logic             ovf_sticky
`endif
);

  logic [WIDTH-1:0] s;
  logic             cout_next;
  logic             carry;

  // Ripple chain of half adders with the carry-in tied high.
  always_comb begin
    carry = 1'b1;
    s     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = A[i] ^ carry;
      carry = A[i] & carry;
    end
    cout_next = carry;
  end

  // Result registers load only on in_valid, so A is never sampled while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      Sum       <= s;
      Cout      <= cout_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef INC16_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (in_valid && cout_next) begin
      ovf_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inc16.sv
// Self-checking bench for inc16: directed steps plus random operands, with a
// queue of expected register contents compared after each clock edge.
module tb_inc16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         out_valid;
`ifdef INC16_OVF_STICKY_EN
  logic         ovf_sticky;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         valid;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t model;
  int   checks   = 0;
  int   failures = 0;

  inc16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
`ifdef INC16_OVF_STICKY_EN
    ,
    .ovf_sticky(ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      assert (out_valid === e.valid) else begin
        failures++;
        $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, e.valid);
      end
      checks++;
      assert (Sum === e.sum) else begin
        failures++;
        $error("[TB] FAIL %s Sum observed=%h expected=%h", tag, Sum, e.sum);
      end
      checks++;
      assert (Cout === e.cout) else begin
        failures++;
        $error("[TB] FAIL %s Cout observed=%b expected=%b", tag, Cout, e.cout);
      end
`ifdef INC16_OVF_STICKY_EN
      checks++;
      assert (ovf_sticky === e.ovf) else begin
        failures++;
        $error("[TB] FAIL %s ovf_sticky observed=%b expected=%b", tag, ovf_sticky, e.ovf);
      end
`endif
    end
  endtask

  // Drive one cycle, advance the reference model, then check after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] a,
                               input string tag);
    logic [W:0] full;
    rst      = r;
    in_valid = v;
    A        = a;
    if (r) begin
      model = '0;
    end else if (v) begin
      full        = {1'b0, a} + 17'd1;
      model.sum   = full[W-1:0];
      model.cout  = full[W];
      model.valid = 1'b1;
      if (full[W]) model.ovf = 1'b1;
    end else begin
      model.valid = 1'b0;
    end
    sbq.push_back(model);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic         rv;
    logic         vv;
    logic [W-1:0] av;
    rst      = 1'b1;
    in_valid = 1'b1;
    A        = 16'hFFFF;
    model    = '0;

    applyStimulus(1'b1, 1'b1, 16'hFFFF, "reset0");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, "reset1");

    applyStimulus(1'b0, 1'b1, 16'h0001, "basic");
    applyStimulus(1'b0, 1'b0, 16'hxxxx, "basic_hold");

    applyStimulus(1'b0, 1'b1, 16'hFFFF, "wrap");
    applyStimulus(1'b0, 1'b1, 16'h0000, "after_wrap");

    applyStimulus(1'b0, 1'b1, 16'hAAAA, "pattern_aaaa");
    applyStimulus(1'b0, 1'b1, 16'h7FFF, "pattern_7fff");
    applyStimulus(1'b0, 1'b0, 16'hxxxx, "idle");

    applyStimulus(1'b0, 1'b1, 16'h0000, "b2b0");
    applyStimulus(1'b0, 1'b1, 16'h00FF, "b2b1");
    applyStimulus(1'b0, 1'b1, 16'hFFFF, "b2b2");

    applyStimulus(1'b1, 1'b1, 16'h1234, "rst_mid");
    applyStimulus(1'b0, 1'b0, 16'hxxxx, "rst_mid_after");
    applyStimulus(1'b0, 1'b0, 16'hxxxx, "rst_mid_after2");

    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 199) == 0);
      vv = ($urandom_range(0, 3) != 0);
      av = vv ? W'($urandom) : 16'hxxxx;
      applyStimulus(rv, vv, av, "random");
    end

    checks++;
    assert (sbq.size() == 0) else begin
      failures++;
      $error("[TB] FAIL drain scoreboard observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
